// File: rtl/pb_pkg.sv
// Shared types for the push-button conditioner: debounce/hold FSM state encoding.
package pb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } pb_state_t;

    // Counter width that can hold values 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: both stages use non-blocking assignments so each edge shifts exactly one stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pb_conditioner.sv
// StopWatch start/stop button front-end: synchronise, debounce, short-press toggle, long-press clear.
module pb_conditioner
    import pb_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 100000000,
    parameter bit PB_ACTIVE_LOW   = 1'b0
) (
    input  logic clk100,
    input  logic reset,
    input  logic pb_raw,
    input  logic clr_run,
    output logic pb_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic run,
    output logic clear_pulse
);

    localparam int DEB_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 1);

    logic              p;
    logic              s;
    pb_state_t         state;
    logic [DEB_W-1:0]  deb_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              long_flag;

    assign p = pb_raw ^ PB_ACTIVE_LOW;

    sync_2ff u_sync (
        .clk   (clk100),
        .rst_n (reset),
        .d     (p),
        .q     (s)
    );

    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            long_flag     <= 1'b0;
            pb_level      <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            run           <= 1'b0;
            clear_pulse   <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            clear_pulse   <= 1'b0;

            // Hold time runs through release bounce and saturates, so the long strobe fires once.
            if ((state == PRESSED || state == RELEASE_WAIT) && hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (hold_cnt == HOLD_PRE) begin
                    long_pulse <= 1'b1;
                    long_flag  <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (s) begin
                        state   <= PRESS_WAIT;
                        deb_cnt <= DEB_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state       <= PRESSED;
                        deb_cnt     <= '0;
                        hold_cnt    <= '0;
                        long_flag   <= 1'b0;
                        press_pulse <= 1'b1;
                        pb_level    <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state   <= RELEASE_WAIT;
                        deb_cnt <= DEB_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state   <= PRESSED;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state         <= IDLE;
                        deb_cnt       <= '0;
                        release_pulse <= 1'b1;
                        pb_level      <= 1'b0;
                        if (long_flag) begin
                            clear_pulse <= 1'b1;
                            run         <= 1'b0;
                        end else begin
                            run <= ~run;
                        end
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    deb_cnt <= '0;
                end
            endcase

            // NOTE: the last non-blocking assignment wins, so an external stop overrides a toggle.
            if (clr_run) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pb_conditioner.sv
// Directed bench for pb_conditioner with short debounce/long thresholds.
module tb_pb_conditioner;

    logic clk100 = 1'b0;
    logic reset  = 1'b0;
    logic pb_raw = 1'b0;
    logic clr_run = 1'b0;
    logic pb_level, press_pulse, release_pulse, long_pulse, run, clear_pulse;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int press_cnt, release_cnt, long_cnt, clear_cnt;
    int press_cyc, release_cyc, long_cyc, clear_cyc;
    int level_seen;
    int start;

    pb_conditioner #(
        .DEBOUNCE_CYCLES (8),
        .LONG_CYCLES     (64),
        .PB_ACTIVE_LOW   (1'b0)
    ) dut (
        .clk100        (clk100),
        .reset         (reset),
        .pb_raw        (pb_raw),
        .clr_run       (clr_run),
        .pb_level      (pb_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .run           (run),
        .clear_pulse   (clear_pulse)
    );

    always #1 clk100 = ~clk100;

    always @(posedge clk100) cyc++;

    // Outputs are sampled on the falling edge, half a period away from the active edge.
    always @(negedge clk100) begin
        if (press_pulse)   begin press_cnt++;   press_cyc   = cyc; end
        if (release_pulse) begin release_cnt++; release_cyc = cyc; end
        if (long_pulse)    begin long_cnt++;    long_cyc    = cyc; end
        if (clear_pulse)   begin clear_cnt++;   clear_cyc   = cyc; end
        if (pb_level) level_seen = 1;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk100);
    endtask

    task automatic clear_counts();
        press_cnt = 0; release_cnt = 0; long_cnt = 0; clear_cnt = 0;
        press_cyc = -1; release_cyc = -1; long_cyc = -1; clear_cyc = -1;
        level_seen = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk100);
        reset = 1'b0; pb_raw = 1'b0; clr_run = 1'b0;
        cycles(3);
        reset = 1'b1;
        cycles(3);
        clear_counts();
    endtask

    task automatic short_press();
        pb_raw = 1'b1; cycles(20);
        pb_raw = 1'b0; cycles(20);
    endtask

    task automatic test_reset();
        @(negedge clk100);
        reset = 1'b0; pb_raw = 1'b1; clr_run = 1'b0;
        cycles(5);
        checks++;
        if ({pb_level, press_pulse, release_pulse, long_pulse, run, clear_pulse} !== 6'b0)
            begin errors++; $display("FAIL reset_outputs: got %b want 000000",
                {pb_level, press_pulse, release_pulse, long_pulse, run, clear_pulse}); end
        clear_counts();
        reset = 1'b1; start = cyc;
        cycles(20);
        checks++; if (press_cnt !== 1) begin errors++; $display("FAIL rst_press_count: got %0d want 1", press_cnt); end
        checks++; if (press_cyc - start !== 10) begin errors++; $display("FAIL rst_press_latency: got %0d want 10", press_cyc - start); end
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL rst_run_held: got %b want 0", run); end
        checks++; if (pb_level !== 1'b1) begin errors++; $display("FAIL rst_level_held: got %b want 1", pb_level); end
        pb_raw = 1'b0; start = cyc;
        cycles(20);
        checks++; if (release_cnt !== 1) begin errors++; $display("FAIL rst_release_count: got %0d want 1", release_cnt); end
        checks++; if (release_cyc - start !== 10) begin errors++; $display("FAIL rst_release_latency: got %0d want 10", release_cyc - start); end
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL rst_run_toggle: got %b want 1", run); end
    endtask

    task automatic test_clean_press();
        apply_reset();
        pb_raw = 1'b1; start = cyc; cycles(20);
        pb_raw = 1'b0; cycles(20);
        checks++; if (press_cyc - start !== 10) begin errors++; $display("FAIL clean_press_latency: got %0d want 10", press_cyc - start); end
        checks++; if (press_cnt !== 1 || release_cnt !== 1)
            begin errors++; $display("FAIL clean_counts1: got press=%0d release=%0d want 1/1", press_cnt, release_cnt); end
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL clean_run_on: got %b want 1", run); end
        short_press();
        checks++; if (press_cnt !== 2 || release_cnt !== 2)
            begin errors++; $display("FAIL clean_counts2: got press=%0d release=%0d want 2/2", press_cnt, release_cnt); end
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL clean_run_off: got %b want 0", run); end
        checks++; if (long_cnt !== 0 || clear_cnt !== 0)
            begin errors++; $display("FAIL clean_no_long: got long=%0d clear=%0d want 0/0", long_cnt, clear_cnt); end
    endtask

    task automatic test_glitch();
        clear_counts();
        pb_raw = 1'b1; cycles(5);
        pb_raw = 1'b0; cycles(20);
        checks++; if (press_cnt !== 0 || release_cnt !== 0)
            begin errors++; $display("FAIL glitch_pulses: got press=%0d release=%0d want 0/0", press_cnt, release_cnt); end
        checks++; if (level_seen !== 0) begin errors++; $display("FAIL glitch_level: got %0d want 0", level_seen); end
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL glitch_run: got %b want 0", run); end
    endtask

    task automatic test_bounce();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            pb_raw = (i % 2 == 0); cycles(3);
        end
        pb_raw = 1'b1; cycles(40);
        checks++; if (press_cnt !== 1) begin errors++; $display("FAIL bounce_press_count: got %0d want 1", press_cnt); end
        checks++; if (release_cnt !== 0) begin errors++; $display("FAIL bounce_no_release: got %0d want 0", release_cnt); end
        for (int i = 0; i < 10; i++) begin
            pb_raw = (i % 2 == 1); cycles(3);
        end
        pb_raw = 1'b0; cycles(40);
        checks++; if (release_cnt !== 1) begin errors++; $display("FAIL bounce_release_count: got %0d want 1", release_cnt); end
        checks++; if (press_cnt !== 1) begin errors++; $display("FAIL bounce_no_repress: got %0d want 1", press_cnt); end
    endtask

    task automatic test_long_press();
        apply_reset();
        short_press();
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL long_setup_run: got %b want 1", run); end
        clear_counts();
        pb_raw = 1'b1; start = cyc; cycles(100);
        checks++; if (long_cnt !== 1) begin errors++; $display("FAIL long_count: got %0d want 1", long_cnt); end
        checks++; if (long_cyc - start !== 74) begin errors++; $display("FAIL long_latency: got %0d want 74", long_cyc - start); end
        checks++; if (run !== 1'b1 || clear_cnt !== 0)
            begin errors++; $display("FAIL long_hold_state: got run=%b clear=%0d want 1/0", run, clear_cnt); end
        pb_raw = 1'b0; cycles(20);
        checks++; if (clear_cnt !== 1 || release_cnt !== 1)
            begin errors++; $display("FAIL long_clear: got clear=%0d release=%0d want 1/1", clear_cnt, release_cnt); end
        checks++; if (clear_cyc !== release_cyc)
            begin errors++; $display("FAIL long_clear_align: got clear@%0d want release@%0d", clear_cyc, release_cyc); end
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL long_run_cleared: got %b want 0", run); end
        checks++; if (long_cnt !== 1) begin errors++; $display("FAIL long_once: got %0d want 1", long_cnt); end
    endtask

    task automatic test_clr_and_reset();
        clear_counts();
        pb_raw = 1'b1; cycles(20);
        pb_raw = 1'b0; start = cyc;
        cycles(9);
        clr_run = 1'b1; cycles(1);
        clr_run = 1'b0; cycles(10);
        checks++; if (release_cnt !== 1 || release_cyc - start !== 10)
            begin errors++; $display("FAIL clr_release: got count=%0d lat=%0d want 1/10", release_cnt, release_cyc - start); end
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL clr_priority: got %b want 0", run); end
        short_press();
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL clr_short_after_long: got %b want 1", run); end
        clr_run = 1'b1; cycles(1);
        clr_run = 1'b0; cycles(1);
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL clr_idle: got %b want 0", run); end
        pb_raw = 1'b1; cycles(20);
        checks++; if (pb_level !== 1'b1) begin errors++; $display("FAIL midpress_level: got %b want 1", pb_level); end
        reset = 1'b0; pb_raw = 1'b0; cycles(3);
        checks++;
        if ({pb_level, press_pulse, release_pulse, long_pulse, run, clear_pulse} !== 6'b0)
            begin errors++; $display("FAIL midpress_reset_outputs: got %b want 000000",
                {pb_level, press_pulse, release_pulse, long_pulse, run, clear_pulse}); end
        reset = 1'b1; clear_counts();
        cycles(30);
        checks++; if (release_cnt !== 0 || press_cnt !== 0)
            begin errors++; $display("FAIL midpress_no_release: got press=%0d release=%0d want 0/0", press_cnt, release_cnt); end
        checks++; if (run !== 1'b0 || pb_level !== 1'b0)
            begin errors++; $display("FAIL midpress_idle: got run=%b level=%b want 0/0", run, pb_level); end
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_long_press();
        test_clr_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
